// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
//
// Captures the two operands for the BCD seven-segment adder from board
// switches using a single push button. Each debounced press latches the
// synchronised switch value into A, then into B, alternately. After a pair
// is complete, the next press starts a new pair by reloading A and skipping
// the WAIT_A state. All outputs are registered.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   sw         in   operand switches (asynchronous to clk)
//   key_n      in   push button, active-low, asynchronous, bouncy
//   A          out  registered operand A to the adder
//   B          out  registered operand B to the adder
//   need_a     out  high while waiting for the A press
//   need_b     out  high while waiting for the B press
//   pair_valid out  high while A and B form a complete pair
// -----------------------------------------------------------------------------
module operand_loader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             key_n,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             need_a,
  output logic             need_b,
  output logic             pair_valid
);

  // Counter only ever holds 0 .. DEBOUNCE_CYCLES-1.
  localparam int            CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    SHOW   = 2'd2
  } state_t;

  logic             key_meta_q, key_sync_q;
  logic [WIDTH-1:0] sw_meta_q, sw_sync_q;

  logic             level_q, level_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             press_q, press_d;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             need_a_q, need_a_d;
  logic             need_b_q, need_b_d;
  logic             pair_valid_q, pair_valid_d;

  // Two-flop synchronisers for the button and the switches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      key_meta_q <= key_n;
      key_sync_q <= key_meta_q;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Debouncer: the level follows the synchronised key only after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles. A press event is raised
  // only on a 1->0 transition of the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (key_sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = key_sync_q;
      cnt_d   = '0;
      press_d = ~key_sync_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Debouncer state and one-cycle press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // FSM state register together with the operand and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_A;
      a_q          <= '0;
      b_q          <= '0;
      need_a_q     <= 1'b1;
      need_b_q     <= 1'b0;
      pair_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      need_a_q     <= need_a_d;
      need_b_q     <= need_b_d;
      pair_valid_q <= pair_valid_d;
    end
  end

  // Next-state logic: a press loads the operand the current state is waiting
  // for. From SHOW a press reloads A and goes straight to WAIT_B.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      WAIT_A: begin
        if (press_q) begin
          a_d     = sw_sync_q;
          state_d = WAIT_B;
        end else begin
          state_d = WAIT_A;
        end
      end
      WAIT_B: begin
        if (press_q) begin
          b_d     = sw_sync_q;
          state_d = SHOW;
        end else begin
          state_d = WAIT_B;
        end
      end
      SHOW: begin
        if (press_q) begin
          a_d     = sw_sync_q;
          state_d = WAIT_B;
        end else begin
          state_d = SHOW;
        end
      end
      default: begin
        // Unused encoding: recover to a clean start without touching operands.
        state_d = WAIT_A;
      end
    endcase
  end

  // Output logic: Moore status decoded from the next state so the status
  // registers change on the same edge as the state register.
  always_comb begin
    need_a_d     = 1'b0;
    need_b_d     = 1'b0;
    pair_valid_d = 1'b0;
    case (state_d)
      WAIT_A:  need_a_d     = 1'b1;
      WAIT_B:  need_b_d     = 1'b1;
      SHOW:    pair_valid_d = 1'b1;
      default: need_a_d     = 1'b1;
    endcase
  end

  assign A          = a_q;
  assign B          = b_q;
  assign need_a     = need_a_q;
  assign need_b     = need_b_q;
  assign pair_valid = pair_valid_q;

endmodule
